// File: rtl/fxp_alu_pkg.sv
// Shared types for the sequential fixed-point ALU: operation codes and FSM states.
package fxp_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/fxp_div_iter.sv
// Restoring unsigned divider: (dividend << FRAC) / divisor, one quotient bit per cycle.
// done is high during the cycle that produces the last bit; quotient then carries the final value.
module fxp_div_iter
  import fxp_alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = W / 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        dividend,
  input  logic [W-1:0]        divisor,
  output logic                busy,
  output logic                done,
  output logic [W+FRAC-1:0]   quotient
);

  localparam int N  = W + FRAC;
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  dvd_reg;
  logic [W-1:0]  dvs_reg;
  logic [W-1:0]  rem_reg;
  logic [N-1:0]  quo_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;

  logic [W:0]    rem_shift;
  logic [W:0]    rem_diff;
  logic          rem_ge;
  logic [W-1:0]  rem_next;
  logic [N-1:0]  quo_next;

  // The remainder stays below the divisor, so after the trial subtraction a
  // clear top bit means the shifted remainder was large enough.
  always_comb begin
    rem_shift = {rem_reg, dvd_reg[N-1]};
    rem_diff  = rem_shift - {1'b0, dvs_reg};
    rem_ge    = ~rem_diff[W];
    rem_next  = rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
    quo_next  = {quo_reg[N-2:0], rem_ge};
  end

  assign busy     = busy_reg;
  assign done     = busy_reg && (cnt_reg == CW'(1));
  assign quotient = quo_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_reg  <= '0;
      dvs_reg  <= '0;
      rem_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      dvd_reg  <= {dividend, {FRAC{1'b0}}};
      dvs_reg  <= divisor;
      rem_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= CW'(N);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      dvd_reg <= dvd_reg << 1;
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fxp_alu_seq.sv
// Sequential signed fixed-point ALU (ADD/SUB/MUL/DIV) with valid/ready handshakes.
// Define FXP_ALU_SAT_EN to saturate overflowing results; otherwise they wrap.
module fxp_alu_seq
  import fxp_alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = W / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         dz
);

  localparam int MW = 2 * W + 2;
  localparam int N  = W + FRAC;

  localparam logic [W-1:0]  RES_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  RES_MIN     = {1'b1, {(W-1){1'b0}}};
  localparam logic [MW-1:0] MAG_NEG_LIM = MW'(1) << (W - 1);
  localparam logic [MW-1:0] MAG_POS_LIM = MAG_NEG_LIM - MW'(1);

`ifdef FXP_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Apply a sign to an unsigned magnitude and range-check it: returns {ovf, result}.
  function automatic logic [W:0] fin_mag(input logic [MW-1:0] mag, input logic neg);
    logic         ovf_f;
    logic [W-1:0] res_f;
    ovf_f = neg ? (mag > MAG_NEG_LIM) : (mag > MAG_POS_LIM);
    res_f = neg ? (~mag[W-1:0] + 1'b1) : mag[W-1:0];
    if (ovf_f && SAT) begin
      res_f = neg ? RES_MIN : RES_MAX;
    end
    return {ovf_f, res_f};
  endfunction

  function automatic logic [W:0] fin_sum(input logic [W:0] s);
    logic         ovf_f;
    logic [W-1:0] res_f;
    ovf_f = s[W] ^ s[W-1];
    res_f = s[W-1:0];
    if (ovf_f && SAT) begin
      res_f = s[W] ? RES_MIN : RES_MAX;
    end
    return {ovf_f, res_f};
  endfunction

  // W+1 bits so that the most negative operand keeps its exact magnitude.
  function automatic logic [W:0] mag_of(input logic [W-1:0] x);
    logic [W:0] ext;
    ext = {x[W-1], x};
    return x[W-1] ? (~ext + 1'b1) : ext;
  endfunction

  state_e        state_reg, state_next;
  logic [W:0]    a_mag_reg, b_mag_reg;
  logic          neg_reg;
  logic [W-1:0]  result_reg;
  logic          ovf_reg;
  logic          dz_reg;

  op_e           op_in;
  logic          accept;
  logic          b_zero;
  logic [W:0]    a_mag, b_mag;
  logic [W:0]    sum_add, sum_sub;
  logic [MW-1:0] mul_prod, mul_mag;
  logic [W:0]    add_fin, sub_fin, mul_fin, div_fin;

  logic          div_start;
  logic          div_busy;
  logic          div_done;
  logic          div_finish;
  logic [N-1:0]  div_quotient;

  assign op_in  = op_e'(op);
  assign accept = in_valid && in_ready;
  assign b_zero = (b == '0);
  assign a_mag  = mag_of(a);
  assign b_mag  = mag_of(b);

  assign sum_add  = {a[W-1], a} + {b[W-1], b};
  assign sum_sub  = {a[W-1], a} - {b[W-1], b};
  assign mul_prod = MW'(a_mag_reg) * MW'(b_mag_reg);
  assign mul_mag  = mul_prod >> FRAC;

  assign add_fin = fin_sum(sum_add);
  assign sub_fin = fin_sum(sum_sub);
  assign mul_fin = fin_mag(mul_mag, neg_reg);
  assign div_fin = fin_mag(MW'(div_quotient), neg_reg);

  assign div_start = accept && (op_in == OP_DIV) && !b_zero;
  // An idle divider while in S_DIV can only mean lost state; leave rather than hang.
  assign div_finish = div_done || !div_busy;

  fxp_div_iter #(
    .W    (W),
    .FRAC (FRAC)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a_mag[W-1:0]),
    .divisor  (b_mag[W-1:0]),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (op_in)
            OP_MUL:  state_next = S_MUL;
            OP_DIV:  state_next = b_zero ? S_DONE : S_DIV;
            default: state_next = S_DONE;
          endcase
        end
      end
      S_MUL: state_next = S_DONE;
      S_DIV: begin
        if (div_finish) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            a_mag_reg <= a_mag;
            b_mag_reg <= b_mag;
            neg_reg   <= a[W-1] ^ b[W-1];
            ovf_reg   <= 1'b0;
            dz_reg    <= 1'b0;
            case (op_in)
              OP_ADD: {ovf_reg, result_reg} <= add_fin;
              OP_SUB: {ovf_reg, result_reg} <= sub_fin;
              OP_DIV: begin
                if (b_zero) begin
                  dz_reg     <= 1'b1;
                  result_reg <= a[W-1] ? RES_MIN : RES_MAX;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: {ovf_reg, result_reg} <= mul_fin;
        S_DIV: begin
          if (div_finish) begin
            {ovf_reg, result_reg} <= div_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign ovf    = ovf_reg;
  assign dz     = dz_reg;

endmodule

// File: doc/fxp_alu_seq.md
FXP_ALU_SEQ -- requirements
Module: fxp_alu_seq

Interface
REQ-001 SHALL have parameter W, default 32: total operand/result width, two's-complement fixed point, W even and >= 8.
REQ-002 SHALL have parameter FRAC, default W/2: fraction bits, 1 <= FRAC <= W-2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands and op are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port op  input  2  operation: ADD=00, SUB=01, MUL=10, DIV=11.
REQ-008 SHALL have ports a, b  input  W  operands, signed Q(W-FRAC).FRAC.
REQ-009 SHALL have port out_valid  output  1  result and flags are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  W  signed fixed-point result.
REQ-012 SHALL have ports ovf, dz  output  1 each  overflow flag, divide-by-zero flag, both qualified by out_valid.

Function
REQ-013 SHALL accept an operation on a cycle where in_valid & in_ready; one operation outstanding at a time.
REQ-014 SHALL use FSM states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL go from IDLE on accept: ADD/SUB/DIV-by-zero -> DONE; MUL -> MUL; DIV -> DIV.
REQ-016 SHALL go from MUL -> DONE after one cycle; from DIV -> DONE after the last quotient bit.
REQ-017 SHALL go from DONE -> IDLE when out_ready; otherwise hold result, ovf and dz stable.
REQ-018 SHALL have latency, measured from the accept edge to out_valid high: ADD/SUB 1, MUL 2, DIV W+FRAC+1, DIV with b==0 1.
REQ-019 SHALL compute ADD/SUB as full-precision W+1-bit sums; ovf=1 when the sum lies outside the signed W-bit range.
REQ-020 SHALL compute MUL on W+1-bit magnitudes: product >> FRAC, truncated toward zero, negated when a[W-1]^b[W-1]; ovf=1 when the magnitude exceeds the signed range.
REQ-021 SHALL compute DIV with a restoring divider: (|a| << FRAC) / |b|, one quotient bit per cycle, truncated toward zero, sign applied as for MUL; ovf=1 on range exceed.
REQ-022 SHALL handle DIV with b==0 as follows: dz=1, ovf=0, result = +max if a>=0, else -max (-2^(W-1)).
REQ-023 SHALL handle a==-2^(W-1) exactly for MUL/DIV (magnitude 2^(W-1) representable).
REQ-024 SHALL ignore in_valid while not IDLE; op/a/b are sampled only at accept.
REQ-025 SHALL allow out_ready high in the DONE cycle, which returns to IDLE; the next accept is possible on the following cycle.

Reset
REQ-026 SHALL, while rst is high, force state=IDLE, in_ready=1 after release, out_valid=0, result=0, ovf=0, dz=0, and clear divider registers.
REQ-027 SHALL, when rst is asserted mid-MUL, mid-DIV or in DONE, discard the operation; no out_valid follows.

Configuration
REQ-028 SHALL, with macro FXP_ALU_SAT_EN defined, clamp overflowing results to +2^(W-1)-1 or -2^(W-1) according to the true sign.
REQ-029 SHALL, without FXP_ALU_SAT_EN, return the low W bits (wrap-around) on overflow; ovf is asserted in both builds.

Structure
REQ-030 SHALL place the op enum (ADD, SUB, MUL, DIV) and the FSM state enum in shared package fxp_alu_pkg.
REQ-031 SHALL implement division in sub-module fxp_div_iter (start, busy, done, magnitudes in, quotient out); all other logic stays in fxp_alu_seq.

Verification (W=32, FRAC=16)
REQ-032 SHALL check MUL a=0x0003_0000, b=0xFFFE_0000 -> result 0xFFFA_0000 (-6.0), out_valid 2 cycles after accept, ovf=0.
REQ-033 SHALL check DIV a=0x0001_0000, b=0x0003_0000 -> result 0x0000_5555, out_valid 49 cycles after accept.
REQ-034 SHALL check DIV a=0xFFFF_0000, b=0 -> dz=1, result 0x8000_0000, latency 1.
REQ-035 SHALL check ADD 0x7FFF_FFFF + 0x0000_0001 -> ovf=1; result 0x7FFF_FFFF with FXP_ALU_SAT_EN, 0x8000_0000 without.
REQ-036 SHALL check holding out_ready=0 for 3 cycles after a SUB -> result/flags stable, in_ready=0, and new in_valid ignored.
REQ-037 SHALL check asserting rst at cycle 10 of a DIV -> out_valid never rises, in_ready=1 after release, and the next ADD completes normally.
